// File: rtl/uart_pkg.sv
// uart_pkg: shared state types and constants for the 8N1 UART
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 104;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronized 8N1 receiver with single-byte holding register and flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] word,
  output logic                 rxne,
  output logic                 ore
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic s1, s2, prev, half_end, bit_end, done;
  assign half_end = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign done = state == RX_STOP && bit_end && s2;
  // synchronizer flops reset high so the idle line never looks like a start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1, s2, prev} <= 3'b111;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      word <= '0;
      rxne <= 1'b0;
      ore <= 1'b0;
    end else begin
      {s1, s2, prev} <= {rx, s1, s2};
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      sh <= sh_nxt;
      rxne <= done | (rxne & ~clear);
      ore <= ~clear & (ore | (done & rxne));
      if (done && (!rxne || clear)) word <= sh;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    sh_nxt = sh;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (prev && !s2) state_nxt = RX_START;
      end
      RX_START: if (half_end) begin
        cnt_nxt = '0;
        idx_nxt = '0;
        state_nxt = s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_end) begin
        cnt_nxt = '0;
        sh_nxt = {s2, sh[DATA_BITS-1:1]};
        idx_nxt = idx + 1'b1;
        if (idx == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
      end
      default: if (bit_end) begin
        cnt_nxt = '0;
        state_nxt = RX_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/uart_top.sv
// uart_top: 8N1 UART with inline transmitter and uart_rx receiver
module uart_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_w_data,
  input  logic                 in_valid,
  output logic                 out_BUSY,
  output logic                 out_signal,
  input  logic                 in_signal,
  input  logic                 in_RXNE_clear,
  output logic [DATA_BITS-1:0] out_word,
  output logic                 out_RXNE,
  output logic                 out_Rx_ORE
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  // line level decoded from the state register so reset forces it high at once
  assign out_BUSY = state != TX_IDLE;
  assign out_signal = state == TX_START ? 1'b0 : state == TX_DATA ? sh[0] : 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= TX_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      sh <= sh_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = (state == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
    idx_nxt = idx;
    sh_nxt = sh;
    case (state)
      TX_IDLE: if (in_valid) begin
        state_nxt = TX_START;
        sh_nxt = in_w_data;
      end
      TX_START: if (bit_end) begin
        state_nxt = TX_DATA;
        idx_nxt = '0;
      end
      TX_DATA: if (bit_end) begin
        sh_nxt = sh >> 1;
        idx_nxt = idx + 1'b1;
        if (idx == 3'(DATA_BITS - 1)) state_nxt = TX_STOP;
      end
      default: if (bit_end) state_nxt = TX_IDLE;
    endcase
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(in_signal),
    .clear(in_RXNE_clear),
    .word(out_word),
    .rxne(out_RXNE),
    .ore(out_Rx_ORE)
  );
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed table-driven checks of uart_top TX framing, RX loopback and flags
module tb_uart_top;
  localparam int CPB = 16;
  logic clk = 0, rst = 1, in_valid = 0, in_RXNE_clear = 0, drv = 1, loop = 0;
  logic [7:0] in_w_data = 0;
  logic out_BUSY, out_signal, out_RXNE, out_Rx_ORE, in_signal;
  logic [7:0] out_word;
  int cmp = 0, bad = 0;
  assign in_signal = loop ? out_signal : drv;
  always #5 clk = ~clk;
  uart_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_w_data(in_w_data), .in_valid(in_valid),
    .out_BUSY(out_BUSY), .out_signal(out_signal), .in_signal(in_signal),
    .in_RXNE_clear(in_RXNE_clear), .out_word(out_word), .out_RXNE(out_RXNE),
    .out_Rx_ORE(out_Rx_ORE)
  );
  typedef struct { logic [7:0] d; logic [9:0] frame; } tx_vec_t;
  typedef struct { logic [7:0] d; logic clr; logic [7:0] word; logic rxne; logic ore; } rx_vec_t;
  tx_vec_t tv[4];
  rx_vec_t rv[5];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic strobe_tx(input logic [7:0] d);
    @(negedge clk);
    in_w_data = d;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic tx_capture(input logic [7:0] d, input int inject, output logic [9:0] frame,
                            output int busy_n, output int unstable);
    logic samp[10*CPB];
    strobe_tx(d);
    busy_n = 0;
    for (int i = 0; i < 10 * CPB + 4; i++) begin
      if (i == inject) begin
        in_w_data = 8'h55;
        in_valid = 1;
      end
      if (i == inject + 1) in_valid = 0;
      if (out_BUSY) busy_n++;
      if (i < 10 * CPB) samp[i] = out_signal;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) frame[k] = samp[k*CPB+CPB/2];
    unstable = 0;
    for (int i = 0; i < 10 * CPB; i++) if (samp[i] !== frame[i/CPB]) unstable++;
  endtask
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drv = f[k];
      repeat (CPB) @(negedge clk);
    end
    drv = 1;
    repeat (2 * CPB) @(negedge clk);
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    in_RXNE_clear = 1;
    @(negedge clk);
    in_RXNE_clear = 0;
  endtask
  initial begin
    logic [9:0] fr;
    int bn, un;
    tv[0] = '{8'h05, 10'h20A};
    tv[1] = '{8'hAA, 10'h354};
    tv[2] = '{8'h00, 10'h200};
    tv[3] = '{8'hFF, 10'h3FE};
    rv[0] = '{8'h05, 1'b1, 8'h05, 1'b1, 1'b0};
    rv[1] = '{8'h04, 1'b1, 8'h04, 1'b1, 1'b0};
    rv[2] = '{8'h03, 1'b1, 8'h03, 1'b1, 1'b0};
    rv[3] = '{8'h02, 1'b0, 8'h02, 1'b1, 1'b0};
    rv[4] = '{8'h08, 1'b1, 8'h02, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check("reset_signal", out_signal, 1);
    check("reset_busy", out_BUSY, 0);
    check("reset_word", out_word, 0);
    check("reset_rxne", out_RXNE, 0);
    check("reset_ore", out_Rx_ORE, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      tx_capture(tv[v].d, -1, fr, bn, un);
      check($sformatf("tx_frame_%02h", tv[v].d), fr, tv[v].frame);
      check($sformatf("tx_busy_len_%02h", tv[v].d), bn, 10 * CPB);
      check($sformatf("tx_bit_width_%02h", tv[v].d), un, 0);
    end
    tx_capture(8'hAA, 3 * CPB, fr, bn, un);
    check("busy_ignore_frame", fr, 10'h354);
    check("busy_ignore_len", bn, 10 * CPB);
    check("busy_ignore_idle", out_BUSY, 0);
    loop = 1;
    for (int v = 0; v < 5; v++) begin
      strobe_tx(rv[v].d);
      for (int n = 0; n < 12 * CPB && out_BUSY; n++) @(negedge clk);
      check($sformatf("rx_tx_done_%0d", v), out_BUSY, 0);
      repeat (4) @(negedge clk);
      check($sformatf("rx_word_%0d", v), out_word, rv[v].word);
      check($sformatf("rx_rxne_%0d", v), out_RXNE, rv[v].rxne);
      check($sformatf("rx_ore_%0d", v), out_Rx_ORE, rv[v].ore);
      if (rv[v].clr) begin
        pulse_clear();
        check($sformatf("rx_clr_rxne_%0d", v), out_RXNE, 0);
        check($sformatf("rx_clr_ore_%0d", v), out_Rx_ORE, 0);
      end
    end
    loop = 0;
    @(negedge clk);
    drv = 0;
    repeat (CPB / 4) @(negedge clk);
    drv = 1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_rxne", out_RXNE, 0);
    drive_frame(8'h5A, 1'b0);
    check("framing_rxne", out_RXNE, 0);
    drive_frame(8'hA5, 1'b1);
    check("manual_rx_rxne", out_RXNE, 1);
    check("manual_rx_word", out_word, 8'hA5);
    pulse_clear();
    strobe_tx(8'hF0);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("mid_frame_bit3", out_signal, 0);
    rst = 1;
    #1;
    check("rst_mid_signal", out_signal, 1);
    check("rst_mid_busy", out_BUSY, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    tx_capture(8'h3C, -1, fr, bn, un);
    check("post_rst_frame", fr, 10'h278);
    check("post_rst_busy_len", bn, 10 * CPB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/uart_top.md
# uart_top

Byte-oriented 8N1 UART with one transmitter and one receiver sharing a single clock. It is the serial endpoint used by the Wishbone system top and by its benches, where one instance drives the system's RX line. The transmit side accepts a byte on a single-cycle strobe. The receive side holds one byte with full and overrun flags until software clears them.

## Interface
- CLKS_PER_BIT, 104, clock cycles per bit (12 MHz / 115200); must be ≥ 4.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_w_data  in  8  byte to transmit; sampled when in_valid is accepted.
- in_valid  in  1  one-cycle transmit strobe.
- out_BUSY  out  1  transmitter is sending a frame.
- out_signal  out  1  serial TX line; idles high.
- in_signal  in  1  serial RX line; asynchronous to clk.
- in_RXNE_clear  in  1  one-cycle strobe that clears out_RXNE and out_Rx_ORE.
- out_word  out  8  last received byte.
- out_RXNE  out  1  receive register holds an unread byte.
- out_Rx_ORE  out  1  overrun: a byte arrived while out_RXNE was set.

## Operation
- Reset values: out_signal=1, out_BUSY=0, out_word=0x00, out_RXNE=0, out_Rx_ORE=0. Both state machines go to IDLE.
- Frame format: start bit (0), then 8 data bits LSB first, then one stop bit (1).
- TX states:
  - IDLE: when in_valid=1, latch in_w_data and go to START.
  - START → DATA (8 bits) → STOP → IDLE.
  - Each state lasts CLKS_PER_BIT cycles, counted by a bit-period counter.
  - in_valid is ignored while out_BUSY=1.
- RX input conditioning: in_signal passes through a 2-flop synchronizer before any use.
- RX states:
  - IDLE: a synchronized falling edge starts a frame and moves to START.
  - START: at half a bit period, re-sample the line. If it is 1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample each bit at its centre, i.e. every CLKS_PER_BIT cycles, shifting LSB first.
  - STOP: sample at the centre of the stop bit.
    - Stop bit = 1 and out_RXNE=0: load out_word and set out_RXNE.
    - Stop bit = 1 and out_RXNE=1: keep out_word unchanged and set out_Rx_ORE.
    - Stop bit = 0 (framing error): discard the byte silently.
  - After STOP, return to IDLE. The receiver can detect the next falling edge immediately.
- Flag clearing: in_RXNE_clear clears both flags.
  - If it coincides with a byte completion in the same cycle, the new byte is loaded, out_RXNE=1 and out_Rx_ORE=0.
- out_Rx_ORE is sticky until cleared.
- Reset asserted mid-frame: out_signal returns high immediately (asynchronously) and any partial RX byte is dropped.

## Timing
- TX start: in_valid accepted at edge N. At edge N+1, out_BUSY=1 and out_signal=0.
- TX duration: out_BUSY falls at edge N+1+10·CLKS_PER_BIT, after the full stop bit. A new in_valid is accepted in that same cycle.
- Back-to-back transmission is therefore possible with zero idle bits between frames.
- RX latency: out_RXNE rises about 2 + 9.5·CLKS_PER_BIT cycles after the falling edge of the start bit on in_signal.
- Bit sampling: a sample occurs at the centre of each bit, with ±1 cycle jitter from the synchronizer.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - typedef tx_state_t {IDLE, START, DATA, STOP};
  - typedef rx_state_t {IDLE, START, DATA, STOP};
  - constants DATA_BITS=8 and the default CLKS_PER_BIT.
- One sub-module, uart_rx, contains the synchronizer, the RX FSM and the flags.
- The transmitter is implemented inline in uart_top.
- Counters are $clog2(CLKS_PER_BIT) bits wide; the bit index is 3 bits wide.

## Test plan
- TX frame: in_valid with 0x05 → out_signal shows 0,1,0,1,0,0,0,0,0,1, each bit exactly CLKS_PER_BIT cycles. out_BUSY is high for 10·CLKS_PER_BIT cycles.
- Loopback receive: tie out_signal to in_signal and send 0x05, 0x04, 0x03, clearing after each byte. out_word matches each byte and out_RXNE=1 within 10·CLKS_PER_BIT+4 cycles.
- Overrun: receive 0x02 then 0x08 without clearing → out_word=0x02, out_RXNE=1, out_Rx_ORE=1. Then in_RXNE_clear → both flags 0.
- Busy strobe ignored: in_valid 0x55 while sending 0xAA → only 0xAA is transmitted and out_BUSY falls on schedule.
- Glitch and framing: a low pulse of CLKS_PER_BIT/4 on in_signal → no reception. A frame with stop bit = 0 → out_RXNE stays 0.
- Reset mid-frame: assert rst during TX bit 3 → out_signal=1 and out_BUSY=0 immediately. The next in_valid sends a complete frame.
